hazard_ctrl: RTL and testbench

- Pipeline sequencer for the 5-stage RISC-V core.
- Decides every cycle whether the PC, IF_ID, ID_EX, EX_MEM and MEM_WB registers advance, hold, flush or take a bubble.
- Inputs it arbitrates between: load-use hazards, ID-stage taken branches, data-memory stall requests.
- Drives the stall_i input of ID_EX and the later pipeline registers, plus the NoOp/bubble select on ID_EX control fields.
- Also provides a memory-timeout watchdog and optional performance counters.

---
 rtl/hazard_ctrl.sv | 131 +++++++++++++
 tb/tb_hazard_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencer for the 5-stage core (stall/flush/bubble).
// Define HAZARD_CTRL_PERF_EN to build the lu/mem/flush perf counters.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [4:0]       RS1addr_i,
  input  logic [4:0]       RS2addr_i,
  input  logic             use_rs2_i,
  input  logic             EX_MemRead_i,
  input  logic [4:0]       EX_RDaddr_i,
  input  logic             branch_taken_i,
  input  logic             mem_stall_i,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             if_id_flush_o,
  output logic             id_ex_bubble_o,
  output logic             pipe_stall_o,
  output logic             err_o,
  output logic [CNT_W-1:0] lu_cnt_o,
  output logic [CNT_W-1:0] mem_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(MEM_TIMEOUT);
  localparam logic [TW-1:0] TONE = TW'(1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    MEM_WAIT
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [TW-1:0] tcnt;
  logic [TW-1:0] tcnt_nxt;
  logic          lu;
  logic          go;

  assign lu = EX_MemRead_i && (EX_RDaddr_i != 5'd0) &&
              ((EX_RDaddr_i == RS1addr_i) ||
               (use_rs2_i && (EX_RDaddr_i == RS2addr_i)));

  // next-state, watchdog count and Mealy control outputs
  always_comb begin
    state_nxt      = state;
    tcnt_nxt       = tcnt;
    go             = 1'b0;
    pc_write_o     = 1'b0;
    if_id_write_o  = 1'b0;
    if_id_flush_o  = 1'b0;
    id_ex_bubble_o = 1'b0;
    pipe_stall_o   = 1'b1;
    case (state)
      IDLE: begin
        if (start_i) state_nxt = RUN;
      end
      RUN: begin
        unique case (1'b1)
          !start_i:                state_nxt = IDLE;
          start_i && mem_stall_i:  state_nxt = MEM_WAIT;
          start_i && !mem_stall_i: go = 1'b1;
        endcase
      end
      MEM_WAIT: begin
        if (mem_stall_i) begin
          if (tcnt != TMAX) tcnt_nxt = tcnt + TONE;
        end else begin
          tcnt_nxt  = '0;
          go        = start_i;
          state_nxt = start_i ? RUN : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (go) begin
      pipe_stall_o = 1'b0;
      if (lu) begin
        id_ex_bubble_o = 1'b1;
      end else begin
        pc_write_o    = 1'b1;
        if_id_write_o = 1'b1;
        if_id_flush_o = branch_taken_i;
      end
    end
  end

  // state, watchdog count and sticky timeout flag
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
      tcnt  <= '0;
      err_o <= 1'b0;
    end else begin
      state <= state_nxt;
      tcnt  <= tcnt_nxt;
      if (tcnt_nxt == TMAX) err_o <= 1'b1;
    end
  end

`ifdef HAZARD_CTRL_PERF_EN
  localparam logic [CNT_W-1:0] CONE = CNT_W'(1);
  logic mem_ev;

  assign mem_ev = mem_stall_i &&
                  (((state == RUN) && start_i) || (state == MEM_WAIT));

  // event counters, wrapping
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      lu_cnt_o    <= '0;
      mem_cnt_o   <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (id_ex_bubble_o) lu_cnt_o <= lu_cnt_o + CONE;
      if (mem_ev) mem_cnt_o <= mem_cnt_o + CONE;
      if (if_id_flush_o) flush_cnt_o <= flush_cnt_o + CONE;
    end
  end
`else
  assign lu_cnt_o    = '0;
  assign mem_cnt_o   = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed stimulus with a per-cycle reference model
// and hand-computed checkpoints for hazard_ctrl.
module tb_hazard_ctrl;

`ifdef HAZARD_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam int T = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  rs1, rs2, rd;
  logic        use2, mr, br, ms;
  logic        pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_stall, err;
  logic [31:0] lu_cnt, mem_cnt, flush_cnt;

  int n_cmp = 0;
  int n_fail = 0;

  hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(32)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .start_i(start),
    .RS1addr_i(rs1),
    .RS2addr_i(rs2),
    .use_rs2_i(use2),
    .EX_MemRead_i(mr),
    .EX_RDaddr_i(rd),
    .branch_taken_i(br),
    .mem_stall_i(ms),
    .pc_write_o(pc_write),
    .if_id_write_o(if_id_write),
    .if_id_flush_o(if_id_flush),
    .id_ex_bubble_o(id_ex_bubble),
    .pipe_stall_o(pipe_stall),
    .err_o(err),
    .lu_cnt_o(lu_cnt),
    .mem_cnt_o(mem_cnt),
    .flush_cnt_o(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: mode 0 = idle, 1 = running, 2 = waiting on memory
  int m_mode, m_to, m_lu, m_mem, m_fl;
  bit m_err;
  int n_mode, n_to, n_lu, n_mem, n_fl;
  bit n_err;

  always @(negedge clk) begin
    bit e_pc, e_ifw, e_fl, e_bub, e_ps, go, memev, hz;
    e_pc = 0; e_ifw = 0; e_fl = 0; e_bub = 0; e_ps = 1;
    go = 0; memev = 0;
    if (!rst) begin
      m_mode = 0; m_to = 0; m_err = 0; m_lu = 0; m_mem = 0; m_fl = 0;
    end
    n_mode = m_mode; n_to = m_to; n_err = m_err;
    n_lu = m_lu; n_mem = m_mem; n_fl = m_fl;
    if (rst) begin
      hz = mr && rd != 0 && (rd == rs1 || (use2 && rd == rs2));
      if (m_mode == 0) begin
        if (start) n_mode = 1;
      end else if (m_mode == 1) begin
        if (!start) n_mode = 0;
        else if (ms) begin memev = 1; n_mode = 2; end
        else go = 1;
      end else begin
        if (ms) begin
          memev = 1;
          n_to = (m_to < T) ? m_to + 1 : T;
          if (n_to == T) n_err = 1;
        end else begin
          n_to = 0;
          n_mode = start ? 1 : 0;
          go = start;
        end
      end
      if (go) begin
        e_ps = 0;
        if (hz) begin
          e_bub = 1;
          n_lu = m_lu + 1;
        end else begin
          e_pc = 1; e_ifw = 1; e_fl = br;
          if (br) n_fl = m_fl + 1;
        end
      end
      if (memev) n_mem = m_mem + 1;
    end
    chk("pc_write", pc_write, e_pc);
    chk("if_id_write", if_id_write, e_ifw);
    chk("if_id_flush", if_id_flush, e_fl);
    chk("id_ex_bubble", id_ex_bubble, e_bub);
    chk("pipe_stall", pipe_stall, e_ps);
    chk("err", err, m_err);
    chk("lu_cnt", lu_cnt, PERF ? 32'(m_lu) : 0);
    chk("mem_cnt", mem_cnt, PERF ? 32'(m_mem) : 0);
    chk("flush_cnt", flush_cnt, PERF ? 32'(m_fl) : 0);
  end

  always @(posedge clk) begin
    if (rst) begin
      m_mode <= n_mode; m_to <= n_to; m_err <= n_err;
      m_lu <= n_lu; m_mem <= n_mem; m_fl <= n_fl;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input bit s, input bit [4:0] r1, input bit [4:0] r2,
                     input bit u2, input bit m, input bit [4:0] d,
                     input bit b, input bit st);
    start = s; rs1 = r1; rs2 = r2; use2 = u2;
    mr = m; rd = d; br = b; ms = st;
  endtask

  initial begin
    rst = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) tick;
    #2;
    chk("rst_stall", pipe_stall, 1);
    chk("rst_pc", pc_write, 0);
    drv(1, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("rst_pc_start", pc_write, 0);
    tick;
    rst = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    tick;
    drv(1, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("idle_pc", pc_write, 0);
    tick;
    #2;
    chk("run_pc", pc_write, 1);
    chk("run_ifw", if_id_write, 1);
    tick;
    // load-use on rs1
    drv(1, 5, 0, 0, 1, 5, 0, 0);
    #2;
    chk("lu_bubble", id_ex_bubble, 1);
    chk("lu_pc", pc_write, 0);
    tick;
    drv(1, 5, 0, 0, 0, 0, 0, 0);
    #2;
    chk("lu_once", id_ex_bubble, 0);
    chk("lu_cnt_1", lu_cnt, PERF ? 1 : 0);
    tick;
    drv(1, 0, 0, 0, 1, 0, 0, 0);
    #2;
    chk("rd0_pc", pc_write, 1);
    chk("rd0_bubble", id_ex_bubble, 0);
    tick;
    // rs2 gating
    drv(1, 3, 7, 0, 1, 7, 0, 0);
    #2;
    chk("rs2_off_pc", pc_write, 1);
    tick;
    drv(1, 3, 7, 1, 1, 7, 0, 0);
    #2;
    chk("rs2_on_bubble", id_ex_bubble, 1);
    tick;
    // branch flush, then branch masked by load-use
    drv(1, 1, 2, 1, 0, 0, 1, 0);
    #2;
    chk("br_flush", if_id_flush, 1);
    tick;
    drv(1, 1, 2, 1, 0, 0, 0, 0);
    #2;
    chk("br_flush_off", if_id_flush, 0);
    chk("flush_cnt_1", flush_cnt, PERF ? 1 : 0);
    tick;
    drv(1, 4, 0, 0, 1, 4, 1, 0);
    #2;
    chk("brlu_flush", if_id_flush, 0);
    chk("brlu_bubble", id_ex_bubble, 1);
    tick;
    drv(1, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("lu_cnt_3", lu_cnt, PERF ? 3 : 0);
    tick;
    // memory stall with pending branch
    for (int i = 0; i < 10; i++) begin
      drv(1, 0, 0, 0, 0, 0, 1, 1);
      #2;
      chk("ms_stall", pipe_stall, 1);
      chk("ms_noflush", if_id_flush, 0);
      tick;
    end
    drv(1, 0, 0, 0, 0, 0, 1, 0);
    #2;
    chk("rel_flush", if_id_flush, 1);
    chk("rel_bubble", id_ex_bubble, 0);
    chk("rel_stall", pipe_stall, 0);
    chk("mem_cnt_10", mem_cnt, PERF ? 10 : 0);
    tick;
    drv(1, 0, 0, 0, 0, 0, 0, 0);
    tick;
    // watchdog
    for (int i = 0; i < 70; i++) begin
      drv(1, 0, 0, 0, 0, 0, 0, 1);
      #2;
      if (i == 64) chk("err_pre", err, 0);
      if (i == 65) chk("err_post", err, 1);
      tick;
    end
    drv(1, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("err_hold", err, 1);
    tick;
    tick;
    // start drops while waiting on memory
    drv(1, 0, 0, 0, 0, 0, 0, 1);
    tick;
    drv(0, 0, 0, 0, 0, 0, 0, 1);
    #2;
    chk("wait_nostart_stall", pipe_stall, 1);
    tick;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("wait_rel_frozen", pc_write, 0);
    tick;
    drv(1, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("back_idle_pc", pc_write, 0);
    tick;
    #2;
    chk("restart_pc", pc_write, 1);
    tick;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("stop_pc", pc_write, 0);
    tick;
    drv(1, 0, 0, 0, 0, 0, 0, 0);
    tick;
    // reset in the middle of a memory stall
    drv(1, 0, 0, 0, 0, 0, 0, 1);
    tick;
    tick;
    rst = 1'b0;
    #1;
    chk("mid_rst_err", err, 0);
    chk("mid_rst_stall", pipe_stall, 1);
    chk("mid_rst_pc", pc_write, 0);
    chk("mid_rst_mem_cnt", mem_cnt, 0);
    tick;
    tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
